// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants for the multiply/divide unit.
//   - op encodings presented on the op port
//   - FSM state encoding
//   - number of shift-add / shift-subtract iterations per operation
package mdu_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CALC  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int ITERATIONS = 32;

endpackage

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32x32 multiply / 32/32 divide, fixed 33-cycle latency.
//
// Ports
//   clk          system clock
//   rst_n        synchronous reset, active low
//   start        request a new operation (sampled while busy=0)
//   op           00=MULTU 01=MULT 10=DIVU 11=DIV
//   A, B         multiplicand/dividend, multiplier/divisor (used at accept only)
//   busy         operation in progress
//   done         one-cycle pulse, hi/lo valid
//   hi, lo       product[63:32]/remainder, product[31:0]/quotient
//   div_by_zero  with done, divide had B=0
//
// state | meaning
// IDLE  | waiting for start
// CALC  | 32 iterations, then sign correction and result load
// DONE  | result valid (done=1); start here chains the next op
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  localparam logic [5:0] ITER_LAST = 6'(ITERATIONS);

  logic [1:0]  state;
  logic [5:0]  count;
  logic        is_div;
  logic        neg_q;    // quotient / product negative
  logic        neg_r;    // remainder negative (dividend sign)
  logic        b_zero;
  logic [31:0] m;        // multiplicand or divisor magnitude
  logic [31:0] acc;      // upper product half / partial remainder
  logic [31:0] sh;       // multiplier shifting out / quotient shifting in

  logic        sel_div, sel_signed, a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic [32:0] add_a, add_b;
  logic [33:0] add_res;
  logic        no_borrow;
  logic [63:0] prod, prod_fix;

  assign sel_div    = (op == OP_DIVU) || (op == OP_DIV);
  assign sel_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg      = sel_signed & A[31];
  assign b_neg      = sel_signed & B[31];
  assign mag_a      = a_neg ? (~A + 32'd1) : A;
  assign mag_b      = b_neg ? (~B + 32'd1) : B;

  // One 33-bit adder serves both ops: add for multiply, subtract for the
  // restoring divide step. Bit 33 is the carry; for subtract it means no borrow.
  always_comb begin
    add_a   = is_div ? {acc, sh[31]} : {1'b0, acc};
    add_b   = {1'b0, m};
    add_res = {1'b0, add_a} + {1'b0, (is_div ? ~add_b : add_b)} + {33'd0, is_div};
  end
  assign no_borrow = add_res[33];

  assign prod     = {acc, sh};
  assign prod_fix = neg_q ? (~prod + 64'd1) : prod;
  assign busy     = (state == ST_CALC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      count       <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      b_zero      <= 1'b0;
      m           <= '0;
      acc         <= '0;
      sh          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state  <= ST_CALC;
            count  <= '0;
            is_div <= sel_div;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            b_zero <= sel_div && (B == 32'd0);
            m      <= sel_div ? mag_b : mag_a;
            sh     <= sel_div ? mag_a : mag_b;
            acc    <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          if (count == ITER_LAST) begin
            state       <= ST_DONE;
            done        <= 1'b1;
            div_by_zero <= b_zero;
            if (is_div) begin
              // B=0 leaves |A| in the remainder, so hi comes back as A naturally.
              lo <= b_zero ? 32'hFFFF_FFFF : (neg_q ? (~sh + 32'd1) : sh);
              hi <= neg_r ? (~acc + 32'd1) : acc;
            end else begin
              hi <= prod_fix[63:32];
              lo <= prod_fix[31:0];
            end
          end else begin
            count <= count + 6'd1;
            if (is_div) begin
              acc <= no_borrow ? add_res[31:0] : {acc[30:0], sh[31]};
              sh  <= {sh[30:0], no_borrow};
            end else if (sh[0]) begin
              acc <= add_res[32:1];
              sh  <= {add_res[0], sh[31:1]};
            end else begin
              acc <= {1'b0, acc[31:1]};
              sh  <= {acc[0], sh[31:1]};
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  mul_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi = 32'd0, exp_lo = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Called at a negedge; the following posedge is the accept edge E0.
  task automatic issue(input vec_t v);
    start = 1'b1; op = v.op; A = v.a; B = v.b;
  endtask

  // Waits through E0..E33, checks latency, hold of old result, and outputs.
  // Returns at the negedge of the done cycle.
  task automatic wait_done(input vec_t v, input bit disturb);
    int lat;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", {63'd0, busy}, 64'd1);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (disturb && lat == 1) begin A = 32'h1234_5678; B = 32'h0000_0009; end
      if (disturb && lat == 4) begin start = 1'b1; op = OP_DIVU; end
      if (disturb && lat == 5) start = 1'b0;
      if (lat == 10) begin
        chk("hold_hi", {32'd0, hi}, {32'd0, exp_hi});
        chk("hold_lo", {32'd0, lo}, {32'd0, exp_lo});
      end
    end
    chk("latency", 64'(lat), 64'd33);
    chk("busy_in_done", {63'd0, busy}, 64'd0);
    chk("hi", {32'd0, hi}, {32'd0, v.hi});
    chk("lo", {32'd0, lo}, {32'd0, v.lo});
    chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, v.dbz});
    exp_hi = v.hi;
    exp_lo = v.lo;
  endtask

  task automatic after_done();
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("dbz_one_cycle", {63'd0, div_by_zero}, 64'd0);
    chk("hi_kept", {32'd0, hi}, {32'd0, exp_hi});
  endtask

  task automatic watch_no_done(input string name, input int cycles);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk(name, 64'(n), 64'd0);
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[4]  = '{OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
    vecs[6]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0};
    vecs[7]  = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0};
    vecs[8]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[9]  = '{OP_MULTU, 32'h1234_5678, 32'd0,         32'd0,         32'd0,         1'b0};
    vecs[10] = '{OP_DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};
    vecs[11] = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         1'b0};
    vecs[12] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd16,        32'd15,        32'h0FFF_FFFF, 1'b0};
    vecs[13] = '{OP_MULT,  32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = OP_MULTU; A = '0; B = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i]);
      wait_done(vecs[i], 1'b0);
      after_done();
      @(negedge clk);
    end

    // Start at E5 ignored, A/B changed after E0; then back-to-back start in DONE.
    v = '{OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0};
    issue(v);
    wait_done(v, 1'b1);
    issue(vecs[3]);
    wait_done(vecs[3], 1'b0);
    after_done();
    watch_no_done("no_extra_done", 40);

    // Reset at E10 of a DIV, with start also asserted; reset wins.
    issue(vecs[2]);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0; start = 1'b1; op = OP_MULTU;
    @(negedge clk);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1; start = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    watch_no_done("no_done_after_rst", 40);
    issue(vecs[1]);
    wait_done(vecs[1], 1'b0);
    after_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL update on the rising edge of clk only.
REQ-002 Port clk, input, 1 bit: system clock shared with the multi-cycle datapath.
REQ-003 Port rst_n, input, 1 bit: synchronous reset, active low.
REQ-004 Port start, input, 1 bit: request a new operation; sampled only while busy=0.
REQ-005 Port op, input, 2 bits: operation select; 00=MULTU, 01=MULT, 10=DIVU, 11=DIV.
REQ-006 Port A, input, 32 bits: multiplicand or dividend.
REQ-007 Port B, input, 32 bits: multiplier or divisor.
REQ-008 Port busy, output, 1 bit: operation in progress; start is ignored while busy=1.
REQ-009 Port done, output, 1 bit: single-cycle pulse marking hi/lo valid.
REQ-010 Port hi, output, 32 bits: product[63:32] or remainder.
REQ-011 Port lo, output, 32 bits: product[31:0] or quotient; feeds the ALUout register mux.
REQ-012 Port div_by_zero, output, 1 bit: set with done when a divide had B=0.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-014 Transitions: IDLE->CALC on start; CALC->DONE after 32 iterations; DONE->CALC on start, otherwise DONE->IDLE.
REQ-015 Start-accept edge E0: latch op, operand magnitudes (absolute values for MULT/DIV), result sign flags, and clear the iteration counter.
REQ-016 Edges E1..E32: perform one shift-add (multiply) or one restoring shift-subtract (divide) step per edge.
REQ-017 Edge E33: apply sign correction, load hi/lo, set done=1, clear busy.
REQ-018 busy SHALL be 1 from E0 through E33.
REQ-019 done SHALL be high for exactly one cycle (E33 to E34).
REQ-020 Latency SHALL be fixed at 33 cycles from start acceptance to done, for all ops and operand values, including divide by zero.
REQ-021 hi/lo SHALL hold their last result until the next done; they SHALL NOT change during CALC.
REQ-022 MULTU: {hi,lo} SHALL equal the unsigned 64-bit product. MULT: {hi,lo} SHALL equal the two's-complement 64-bit product.
REQ-023 DIVU/DIV: quotient truncates toward zero; remainder sign equals dividend sign; |remainder| < |divisor|.
REQ-024 Divide with B=0: lo=32'hFFFF_FFFF, hi=A, div_by_zero=1 in the done cycle; otherwise div_by_zero=0.
REQ-025 DIV 32'h8000_0000 / 32'hFFFF_FFFF SHALL yield lo=32'h8000_0000, hi=0, div_by_zero=0.
REQ-026 start asserted while busy=1 SHALL be ignored, with no effect on the current operation.
REQ-027 start in the DONE cycle SHALL be accepted, giving back-to-back operations with no idle cycle.
REQ-028 A and B need be stable only at the accept edge E0; later changes SHALL NOT affect the result.

Reset
REQ-029 rst_n=0 at a clock edge SHALL set state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, and clear the counter and internal registers.
REQ-030 Reset mid-operation SHALL abort the operation with no done pulse; reset SHALL take priority over start in the same cycle.

Structure
REQ-031 Shared package mdu_pkg SHALL hold the op encodings (MULTU, MULT, DIVU, DIV), the FSM state encoding, and the constant ITERATIONS=32.
REQ-032 The block SHALL be a single module with no sub-module; the negate/absolute-value logic stays inline, with one shared 33-bit adder/subtractor used for both multiply and divide.

Verification
REQ-033 MULTU A=32'hFFFF_FFFF, B=32'hFFFF_FFFF -> done at E33; hi=32'hFFFF_FFFE, lo=32'h0000_0001.
REQ-034 MULT A=-3, B=5 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1.
REQ-035 DIV A=-7, B=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF. DIVU A=100, B=7 -> lo=14, hi=2.
REQ-036 DIVU A=100, B=0 -> done at E33; lo=32'hFFFF_FFFF, hi=100, div_by_zero=1 for exactly that cycle.
REQ-037 start pulsed at E5 of a running MULTU, with A/B changed after E0 -> single done at E33 with the original result; start in the DONE cycle -> second done exactly 33 cycles later.
REQ-038 rst_n=0 at E10 of a DIV -> next cycle busy=0, done=0, hi=lo=0; no done pulse follows, and the next start completes normally.
